// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the sequential radix-2 butterfly.
//   state_t     - butterfly FSM states
//   TIMEOUT_DEF - default multiplier wait budget, in cycles
//   ow_f()      - result width: DW+1 at full precision, DW when the
//                 FFT_BFLY_SCALE_EN macro selects halving of the results
package fft_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT, OUT} state_t;

  localparam int TIMEOUT_DEF = 15;

  function automatic int ow_f(input int dw);
`ifdef FFT_BFLY_SCALE_EN
    return dw;
`else
    return dw + 1;
`endif
  endfunction

endpackage

// File: rtl/fft_bfly_add.sv
// fft_bfly_add: combinational butterfly add/sub stage.
//   i_a_*  - operand A (signed, DW bits)
//   i_wb_* - product W*B (signed, DW bits)
//   o_x0_* - A + W*B, o_x1_* - A - W*B (signed, OW bits)
// Sums are formed at DW+1 bits so nothing can overflow. With the
// FFT_BFLY_SCALE_EN macro defined, each sum is arithmetically shifted
// right by one (floor) back to DW bits.
module fft_bfly_add
  import fft_pkg::*;
#(
  parameter  int DW = 16,
  localparam int OW = ow_f(DW)
) (
  input  logic signed [DW-1:0] i_a_i,
  input  logic signed [DW-1:0] i_a_q,
  input  logic signed [DW-1:0] i_wb_i,
  input  logic signed [DW-1:0] i_wb_q,
  output logic signed [OW-1:0] o_x0_i,
  output logic signed [OW-1:0] o_x0_q,
  output logic signed [OW-1:0] o_x1_i,
  output logic signed [OW-1:0] o_x1_q
);

  logic signed [DW:0] w_s0_i, w_s0_q, w_s1_i, w_s1_q;

  assign w_s0_i = {i_a_i[DW-1], i_a_i} + {i_wb_i[DW-1], i_wb_i};
  assign w_s0_q = {i_a_q[DW-1], i_a_q} + {i_wb_q[DW-1], i_wb_q};
  assign w_s1_i = {i_a_i[DW-1], i_a_i} - {i_wb_i[DW-1], i_wb_i};
  assign w_s1_q = {i_a_q[DW-1], i_a_q} - {i_wb_q[DW-1], i_wb_q};

`ifdef FFT_BFLY_SCALE_EN
  // Dropping the LSB of a two's-complement value is a floor divide by 2.
  logic w_unused_lsb;
  assign w_unused_lsb = w_s0_i[0] ^ w_s0_q[0] ^ w_s1_i[0] ^ w_s1_q[0];
  assign o_x0_i = w_s0_i[DW:1];
  assign o_x0_q = w_s0_q[DW:1];
  assign o_x1_i = w_s1_i[DW:1];
  assign o_x1_q = w_s1_q[DW:1];
`else
  assign o_x0_i = w_s0_i;
  assign o_x0_q = w_s0_q;
  assign o_x1_i = w_s1_i;
  assign o_x1_q = w_s1_q;
`endif

endmodule

// File: rtl/fft_bfly_seq.sv
// fft_bfly_seq: sequential radix-2 DIT butterfly around an external
// twiddle multiplier. One pair is in flight at a time.
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     - operand handshake (A, B, twiddle index in_fi)
//   mult_en               - one-cycle start pulse to the multiplier
//   mult_fi_deg, mult_in_*- index and operand B held for the multiplier
//   mult_res_*, mult_valid- W*B and the multiplier idle/result level
//   out_valid/out_ready   - result handshake, x0 = A+W*B, x1 = A-W*B
//   err_timeout           - sticky: multiplier did not answer in TIMEOUT cycles
// Macro FFT_BFLY_SCALE_EN halves the results to DATA_FFT_SIZE bits.
module fft_bfly_seq
  import fft_pkg::*;
#(
  parameter  int SIZE_DATA_FI  = 6,
  parameter  int DATA_FFT_SIZE = 16,
  parameter  int TIMEOUT       = TIMEOUT_DEF,
  localparam int OW            = ow_f(DATA_FFT_SIZE)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [DATA_FFT_SIZE-1:0] in_a_i,
  input  logic signed [DATA_FFT_SIZE-1:0] in_a_q,
  input  logic signed [DATA_FFT_SIZE-1:0] in_b_i,
  input  logic signed [DATA_FFT_SIZE-1:0] in_b_q,
  input  logic [15:0]                     in_fi,
  output logic                            mult_en,
  output logic [15:0]                     mult_fi_deg,
  output logic signed [DATA_FFT_SIZE-1:0] mult_in_i,
  output logic signed [DATA_FFT_SIZE-1:0] mult_in_q,
  input  logic signed [DATA_FFT_SIZE-1:0] mult_res_i,
  input  logic signed [DATA_FFT_SIZE-1:0] mult_res_q,
  input  logic                            mult_valid,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [OW-1:0]            out_x0_i,
  output logic signed [OW-1:0]            out_x0_q,
  output logic signed [OW-1:0]            out_x1_i,
  output logic signed [OW-1:0]            out_x1_q,
  output logic                            err_timeout
);

  localparam int FW = SIZE_DATA_FI - 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t r_state, w_next;

  logic signed [DATA_FFT_SIZE-1:0] r_a_i, r_a_q, r_b_i, r_b_q;
  logic [FW-1:0]                   r_fi;
  logic [CW-1:0]                   r_cnt;
  logic                            r_err;
  logic signed [OW-1:0]            r_x0_i, r_x0_q, r_x1_i, r_x1_q;

  logic                            w_accept, w_cap, w_tmo;
  logic signed [DATA_FFT_SIZE-1:0] w_wb_i, w_wb_q;
  logic signed [OW-1:0]            w_x0_i, w_x0_q, w_x1_i, w_x1_q;
  logic                            w_unused_fi;

  // Upper index bits have no meaning for this FFT size.
  assign w_unused_fi = ^in_fi[15:FW];

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    mult_en  = 1'b0;
    w_accept = 1'b0;
    w_cap    = 1'b0;
    w_tmo    = 1'b0;
    case (r_state)
      IDLE: begin
        // A busy multiplier (mult_valid low) blocks new work.
        in_ready = mult_valid & ~reset;
        if (in_valid && in_ready) begin
          w_accept = 1'b1;
          w_next   = ISSUE;
        end
      end
      ISSUE: begin
        mult_en = ~reset;
        w_next  = GUARD;
      end
      // mult_valid may still show the idle level from before the start
      // pulse, so it is not trusted for one cycle.
      GUARD: w_next = WAIT;
      WAIT: begin
        if (mult_valid) begin
          w_cap  = 1'b1;
          w_next = OUT;
        end else if (r_cnt == CNT_LAST) begin
          w_tmo  = 1'b1;
          w_cap  = 1'b1;
          w_next = OUT;
        end
      end
      OUT: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // On timeout the product is taken as zero, giving x0 = x1 = A.
  assign w_wb_i = w_tmo ? '0 : mult_res_i;
  assign w_wb_q = w_tmo ? '0 : mult_res_q;

  fft_bfly_add #(.DW(DATA_FFT_SIZE)) u_add (
    .i_a_i  (r_a_i),
    .i_a_q  (r_a_q),
    .i_wb_i (w_wb_i),
    .i_wb_q (w_wb_q),
    .o_x0_i (w_x0_i),
    .o_x0_q (w_x0_q),
    .o_x1_i (w_x1_i),
    .o_x1_q (w_x1_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_a_i   <= '0;
      r_a_q   <= '0;
      r_b_i   <= '0;
      r_b_q   <= '0;
      r_fi    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_x0_i  <= '0;
      r_x0_q  <= '0;
      r_x1_i  <= '0;
      r_x1_q  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a_i <= in_a_i;
        r_a_q <= in_a_q;
        r_b_i <= in_b_i;
        r_b_q <= in_b_q;
        r_fi  <= in_fi[FW-1:0];
      end
      // Counter sits at zero outside WAIT, so every WAIT entry starts fresh.
      if (r_state != WAIT)
        r_cnt <= '0;
      else if (!w_cap)
        r_cnt <= r_cnt + CW'(1);
      if (w_tmo)
        r_err <= 1'b1;
      if (w_cap) begin
        r_x0_i <= w_x0_i;
        r_x0_q <= w_x0_q;
        r_x1_i <= w_x1_i;
        r_x1_q <= w_x1_q;
      end
    end
  end

  assign out_valid   = (r_state == OUT) & ~reset;
  assign mult_fi_deg = 16'(r_fi);
  assign mult_in_i   = r_b_i;
  assign mult_in_q   = r_b_q;
  assign out_x0_i    = r_x0_i;
  assign out_x0_q    = r_x0_q;
  assign out_x1_i    = r_x1_i;
  assign out_x1_q    = r_x1_q;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_fft_bfly_seq.sv
// Testbench for fft_bfly_seq: scoreboard of expected butterflies, an
// external multiplier model with configurable latency, and a monitor that
// checks results, latency, back-pressure stability and the timeout flag.
module tb_fft_bfly_seq;

  localparam int DW      = 16;
  localparam int SFI     = 6;
  localparam int TO      = 15;
  localparam int OW      = fft_pkg::ow_f(DW);
  localparam int FI_MASK = (1 << (SFI - 1)) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [DW-1:0] in_a_i = '0, in_a_q = '0, in_b_i = '0, in_b_q = '0;
  logic [15:0] in_fi = '0;
  logic mult_en;
  logic [15:0] mult_fi_deg;
  logic signed [DW-1:0] mult_in_i, mult_in_q;
  logic signed [DW-1:0] mult_res_i = '0, mult_res_q = '0;
  logic mult_valid = 1'b1;
  logic out_valid;
  logic out_ready = 1'b0;
  logic signed [OW-1:0] out_x0_i, out_x0_q, out_x1_i, out_x1_q;
  logic err_timeout;

  fft_bfly_seq #(.SIZE_DATA_FI(SFI), .DATA_FFT_SIZE(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a_i(in_a_i), .in_a_q(in_a_q), .in_b_i(in_b_i), .in_b_q(in_b_q),
    .in_fi(in_fi),
    .mult_en(mult_en), .mult_fi_deg(mult_fi_deg),
    .mult_in_i(mult_in_i), .mult_in_q(mult_in_q),
    .mult_res_i(mult_res_i), .mult_res_q(mult_res_q), .mult_valid(mult_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x0_i(out_x0_i), .out_x0_q(out_x0_q),
    .out_x1_i(out_x1_i), .out_x1_q(out_x1_q),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x0i, x0q, x1i, x1q;
    int acc, lat;
    bit err, first_tmo;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0, cyc = 0;
  bit   err_exp = 1'b0;
  bit   ordy_hold = 1'b0;

  // Pending job for the multiplier model
  int nx_bi, nx_bq, nx_fi, nx_wbi, nx_wbq, nx_d;
  bit nx_hang;
  int m_cnt = 0;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int bfly(input int a, input int wb, input bit sub);
    int r;
    r = sub ? a - wb : a + wb;
`ifdef FFT_BFLY_SCALE_EN
    r = r >>> 1;
`endif
    return r;
  endfunction

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  always @(posedge clk) cyc++;

  // Multiplier: drops mult_valid on a start pulse, answers d cycles later.
  always @(negedge clk) begin
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        mult_valid = 1'b1;
        mult_res_i = nx_wbi[DW-1:0];
        mult_res_q = nx_wbq[DW-1:0];
      end
    end else if (mult_en === 1'b1) begin
      chk("mult_fi_deg", int'(mult_fi_deg), nx_fi & FI_MASK);
      chk("mult_in_i", int'(mult_in_i), nx_bi);
      chk("mult_in_q", int'(mult_in_q), nx_bq);
      mult_valid = 1'b0;
      m_cnt = nx_hang ? TO + 8 : nx_d;
    end
  end

  always @(negedge clk)
    out_ready = ordy_hold ? 1'b0 : ($urandom_range(0, 3) != 0);

  // Monitor
  bit   prev_ov = 1'b0, prev_hs = 1'b0, prev_err = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    #2;
    if (out_valid) begin
      if (!prev_ov || prev_hs) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          cur = q.pop_front();
          chk("x0_i", int'(out_x0_i), cur.x0i);
          chk("x0_q", int'(out_x0_q), cur.x0q);
          chk("x1_i", int'(out_x1_i), cur.x1i);
          chk("x1_q", int'(out_x1_q), cur.x1q);
          chk("latency", cyc - cur.acc, cur.lat);
          chk("err_timeout", int'(err_timeout), int'(cur.err));
          if (cur.first_tmo) chk("err_before_timeout", int'(prev_err), 0);
        end
      end else begin
        chk("hold_x0_i", int'(out_x0_i), cur.x0i);
        chk("hold_x0_q", int'(out_x0_q), cur.x0q);
        chk("hold_x1_i", int'(out_x1_i), cur.x1i);
        chk("hold_x1_q", int'(out_x1_q), cur.x1q);
        chk("hold_in_ready", int'(in_ready), 0);
      end
    end
    prev_ov  = out_valid;
    prev_hs  = out_valid & out_ready;
    prev_err = err_timeout;
  end

  task automatic send(input int ai, aq, bi, bq, fi, wbi, wbq, d,
                      input bit hang, input bit push);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a_i = ai[DW-1:0]; in_a_q = aq[DW-1:0];
    in_b_i = bi[DW-1:0]; in_b_q = bq[DW-1:0];
    in_fi  = fi[15:0];
    #1;
    while (!in_ready && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      chk("accept_wait", 0, 1);
      in_valid = 1'b0;
      return;
    end
    nx_bi = bi; nx_bq = bq; nx_fi = fi; nx_wbi = wbi; nx_wbq = wbq;
    nx_d = d; nx_hang = hang;
    e.x0i = bfly(ai, hang ? 0 : wbi, 1'b0);
    e.x0q = bfly(aq, hang ? 0 : wbq, 1'b0);
    e.x1i = bfly(ai, hang ? 0 : wbi, 1'b1);
    e.x1q = bfly(aq, hang ? 0 : wbq, 1'b1);
    e.acc = cyc;
    // ISSUE + GUARD, then WAIT until the product or the timeout.
    e.lat = hang ? 3 + TO : ((2 + d > 4) ? 2 + d : 4);
    e.first_tmo = hang && !err_exp;
    if (hang && push) err_exp = 1'b1;
    e.err = err_exp;
    if (push) q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk); n++;
    end
    #3;
    chk("drain", q.size(), 0);
  endtask

  initial begin
    int n, ai, aq, bi, bq, wi, wq;
    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_mult_en", int'(mult_en), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_err", int'(err_timeout), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #2;
    chk("rst_x0_i", int'(out_x0_i), 0);
    chk("rst_x1_q", int'(out_x1_q), 0);
    chk("rst_mult_in_i", int'(mult_in_i), 0);
    chk("idle_in_ready", int'(in_ready), 1);

    // Basic: multiplier echoes B after 4 cycles
    send(100, -50, 20, 30, 0, 20, 30, 4, 1'b0, 1'b1);
    drain();
    // Extremes, no overflow at full precision
    send(32767, 32767, 5, 6, 7, 32767, -32768, 4, 1'b0, 1'b1);
    drain();

    // Back-pressure for 10 cycles
    ordy_hold = 1'b1;
    send(-1234, 4321, 77, -88, 3, -500, 600, 3, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk); #2; n++;
    end
    repeat (10) @(negedge clk);
    #2;
    chk("bp_still_valid", int'(out_valid), 1);
    ordy_hold = 1'b0;
    drain();

    // Random traffic
    for (int k = 0; k < 20; k++) begin
      ai = rnd(-32768, 32767); aq = rnd(-32768, 32767);
      bi = rnd(-32768, 32767); bq = rnd(-32768, 32767);
      wi = rnd(-32768, 32767); wq = rnd(-32768, 32767);
      send(ai, aq, bi, bq, rnd(0, 65535), wi, wq, rnd(1, 8), 1'b0, 1'b1);
    end
    drain();

    // Timeout, then a normal pair with the flag still set
    send(-300, 900, 11, 22, 9, 1, 2, 4, 1'b1, 1'b1);
    send(1000, -2000, 3, 4, 1, 250, -125, 4, 1'b0, 1'b1);
    drain();

    // Reset while in WAIT; the late product must produce no output
    send(555, -555, 1, 1, 2, 9, 9, 4, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    err_exp = 1'b0;
    #2;
    chk("rst_wait_out_valid", int'(out_valid), 0);
    chk("rst_wait_mult_en", int'(mult_en), 0);
    chk("rst_wait_in_ready", int'(in_ready), 0);
    chk("rst_wait_err", int'(err_timeout), 0);
    n = 0;
    while (!mult_valid && n < 100) begin
      @(negedge clk); #2; n++;
    end
    chk("late_mult_valid", int'(mult_valid), 1);
    repeat (5) @(negedge clk);
    send(-7, 8, 2, 3, 4, 40, -41, 2, 1'b0, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d want=0", cyc);
    $fatal(1);
  end

endmodule
